// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : funct3 codes, FSM state encoding and decode helpers for the LSU.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        FAULT  = 2'd3
    } lsu_state_t;

    // Stores only have B/H/W; loads additionally have BU/HU.
    function automatic logic f3_illegal(input logic write, input logic [2:0] funct3);
        if (write) begin
            return funct3 > F3_W;
        end
        return (funct3 == 3'd3) || (funct3 > F3_HU);
    endfunction

    // Access size is carried in funct3[1:0] for every legal encoding.
    function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extender.sv
`default_nettype none
// ============================================================================
// Module   : load_extender
// Purpose  : Selects the byte/halfword lane of a memory word and extends it.
// Revision : 1.0
// ============================================================================
module load_extender
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_word,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_byte_off, 3'b000} +: 8];
        w_half = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_result = 32'd0;
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_W:    o_result = i_word;
            F3_BU:   o_result = {24'd0, w_byte};
            F3_HU:   o_result = {16'd0, w_half};
            default: o_result = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : RV32I load/store initiator for a single-port masked-write memory.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_misaligned,
    output logic                  resp_illegal,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [31:0]           mem_write_data,
    output logic [3:0]            mem_write_mask,
    input  logic [31:0]           mem_read_data
);

    lsu_state_t r_state;
    lsu_state_t w_state_nxt;

    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic                  r_write;
    logic                  r_illegal;
    logic                  r_misaligned;
    logic [31:0]           r_rdata;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_mask;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_fault;
    logic [3:0]            w_lane_mask;
    logic [31:0]           w_lane_data;
    logic [31:0]           w_ext;
    logic                  w_unused_addr_hi;

    // Upper address bits are deliberately dropped: the memory wraps.
    assign w_unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign w_illegal    = f3_illegal(req_write, req_funct3);
    assign w_misaligned = f3_misaligned(req_funct3, req_addr[1:0]) && !w_illegal;
    assign w_fault      = w_illegal || w_misaligned;

    always_comb begin
        w_lane_mask = 4'b0000;
        w_lane_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_lane_mask = 4'b0001 << req_addr[1:0];
                w_lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_lane_mask = 4'b1111;
            end
            default: ;
        endcase
    end

    load_extender u_load_extender (
        .i_funct3   (r_funct3),
        .i_byte_off (r_off),
        .i_word     (mem_read_data),
        .o_result   (w_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'd0;
        resp_misaligned = 1'b0;
        resp_illegal    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_fault ? FAULT : ACCESS;
                end
            end
            ACCESS: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                resp_valid  = 1'b1;
                resp_rdata  = r_rdata;
                w_state_nxt = IDLE;
            end
            FAULT: begin
                resp_valid      = 1'b1;
                resp_illegal    = r_illegal;
                resp_misaligned = r_misaligned;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Memory strobes are set up at acceptance so they are live for exactly the ACCESS cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct3      <= 3'd0;
            r_off         <= 2'd0;
            r_write       <= 1'b0;
            r_illegal     <= 1'b0;
            r_misaligned  <= 1'b0;
            r_rdata       <= 32'd0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= 32'd0;
            r_mem_mask    <= 4'b0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3     <= req_funct3;
                        r_off        <= req_addr[1:0];
                        r_write      <= req_write;
                        r_illegal    <= w_illegal;
                        r_misaligned <= w_misaligned;
                        if (!w_fault) begin
                            r_mem_address <= req_addr[ADDR_WIDTH+1:2];
                            r_mem_we      <= req_write;
                            r_mem_mask    <= req_write ? w_lane_mask : 4'b0000;
                            r_mem_wdata   <= req_write ? w_lane_data : 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    r_mem_we   <= 1'b0;
                    r_mem_mask <= 4'b0000;
                    r_rdata    <= r_write ? 32'd0 : w_ext;
                end
                default: ;
            endcase
        end
    end

    assign mem_write_enable = r_mem_we;
    assign mem_address      = r_mem_address;
    assign mem_write_data   = r_mem_wdata;
    assign mem_write_mask   = r_mem_mask;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Self-checking bench for load_store_unit with a byte-level model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_misaligned;
    logic          resp_illegal;
    logic          mem_write_enable;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_write_data;
    logic [3:0]    mem_write_mask;
    logic [31:0]   mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    // DataMemory stand-in plus a byte-addressed reference image (4 KiB).
    logic [31:0]   dmem [0:1023];
    logic [7:0]    ref_bytes [0:4095];
    logic          bd_clear;
    logic          bd_we;
    logic [AW-1:0] bd_idx;
    logic [31:0]   bd_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_misaligned  (resp_misaligned),
        .resp_illegal     (resp_illegal),
        .mem_write_enable (mem_write_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_mask   (mem_write_mask),
        .mem_read_data    (mem_read_data)
    );

    always @(posedge clk) begin
        if (bd_clear) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 32'd0;
        end else if (bd_we) begin
            dmem[bd_idx] <= bd_data;
        end else if (mem_write_enable) begin
            for (int i = 0; i < 4; i++)
                if (mem_write_mask[i]) dmem[mem_address][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
    end
    assign mem_read_data = dmem[mem_address];

    // ---------------- reference model ----------------
    function automatic logic ref_illegal(input logic w, input logic [2:0] f3);
        if (w) return f3 > 3'd2;
        return (f3 == 3'd3) || (f3 >= 3'd6);
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic ref_misaligned(input logic w, input logic [2:0] f3, input logic [31:0] a);
        if (ref_illegal(w, f3)) return 1'b0;
        return (int'(a[1:0]) % ref_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int base = int'(a[11:0]);
        int n    = ref_size(f3);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_step(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic mis, output logic ill);
        ill = ref_illegal(w, f3);
        mis = ref_misaligned(w, f3, a);
        rd  = 32'd0;
        if (!ill && !mis) begin
            if (w) begin
                for (int i = 0; i < ref_size(f3); i++) ref_bytes[int'(a[11:0]) + i] = wd[8*i +: 8];
            end else begin
                rd = ref_load(f3, a);
            end
        end
    endtask

    // Drives one request from IDLE, returns the ACCESS-cycle memory strobes and the response.
    // lat counts edges after acceptance until resp_valid; -1 means no response arrived.
    task automatic run_txn(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic hold, output int lat, output logic [31:0] rd, output logic mis,
                           output logic ill, output logic a_we, output logic [3:0] a_mask,
                           output logic [31:0] a_data, output logic [AW-1:0] a_addr, output logic overlap);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        if (hold) begin
            req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
        end else begin
            req_valid = 1'b0;
        end
        a_we = mem_write_enable; a_mask = mem_write_mask; a_data = mem_write_data; a_addr = mem_address;
        overlap = resp_valid && req_ready;
        lat = 0;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            overlap = overlap | (resp_valid && req_ready);
        end
        if (!resp_valid) lat = -1;
        rd = resp_rdata; mis = resp_misaligned; ill = resp_illegal;
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    int          lat;
    logic [31:0] rd, a_data, e_rd;
    logic        mis, ill, a_we, ovl, e_mis, e_ill;
    logic [3:0]  a_mask;
    logic [AW-1:0] a_addr;

    task automatic test_reset();
        reset = 1'b1; bd_clear = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = 32'd0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal, mem_write_enable,
             mem_address, mem_write_data, mem_write_mask} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b valid=%b rdata=%h we=%b addr=%h wdata=%h mask=%b, required ready=1 rest 0",
                     req_ready, resp_valid, resp_rdata, mem_write_enable, mem_address, mem_write_data, mem_write_mask);
        end
        reset = 1'b0; bd_clear = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_load_word();
        bd_we = 1'b1; bd_idx = 10'd1; bd_data = 32'hDEAD_BEEF;
        {ref_bytes[7], ref_bytes[6], ref_bytes[5], ref_bytes[4]} = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_step(1'b0, 3'd2, 32'h4, 32'd0, e_rd, e_mis, e_ill);
        run_txn(1'b0, 3'd2, 32'h4, 32'd0, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL lw_latency: got %0d required 1", lat); end
        n_checks++;
        if ({rd, mis, ill} !== {32'hDEAD_BEEF, 2'b00}) begin
            n_fail++; $display("FAIL lw_resp: got %h/%b%b required deadbeef/00", rd, mis, ill);
        end
        n_checks++;
        if ({a_we, a_mask, a_addr} !== {1'b0, 4'b0000, 10'd1}) begin
            n_fail++; $display("FAIL lw_access: got we=%b mask=%b addr=%h required 0/0000/001", a_we, a_mask, a_addr);
        end
    endtask

    task automatic test_store_lanes();
        ref_step(1'b1, 3'd2, 32'h4, 32'hDEAD_BEEF, e_rd, e_mis, e_ill);
        run_txn(1'b1, 3'd2, 32'h4, 32'hDEAD_BEEF, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({lat, a_we, a_mask, a_data, rd} !== {32'sd1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 32'd0}) begin
            n_fail++; $display("FAIL sw_access: got lat=%0d we=%b mask=%b data=%h rd=%h", lat, a_we, a_mask, a_data, rd);
        end
        ref_step(1'b1, 3'd0, 32'h7, 32'h0000_00FE, e_rd, e_mis, e_ill);
        run_txn(1'b1, 3'd0, 32'h7, 32'h0000_00FE, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({a_we, a_mask, a_data, a_addr} !== {1'b1, 4'b1000, 32'hFEFE_FEFE, 10'd1}) begin
            n_fail++; $display("FAIL sb_access: got we=%b mask=%b data=%h addr=%h required 1/1000/fefefefe/001",
                               a_we, a_mask, a_data, a_addr);
        end
        run_txn(1'b0, 3'd2, 32'h4, 32'd0, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if (rd !== 32'hFEAD_BEEF) begin n_fail++; $display("FAIL sb_readback: got %h required feadbeef", rd); end

        ref_step(1'b1, 3'd1, 32'h6, 32'h0000_CAFE, e_rd, e_mis, e_ill);
        run_txn(1'b1, 3'd1, 32'h6, 32'h0000_CAFE, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({a_mask, a_data} !== {4'b1100, 32'hCAFE_CAFE}) begin
            n_fail++; $display("FAIL sh_access: got mask=%b data=%h required 1100/cafecafe", a_mask, a_data);
        end
    endtask

    task automatic test_load_extend();
        logic [2:0]  f3s [4] = '{3'd1, 3'd5, 3'd0, 3'd4};
        logic [31:0] ads [4] = '{32'h6, 32'h6, 32'h5, 32'h5};
        logic [31:0] exs [4] = '{32'hFFFF_CAFE, 32'h0000_CAFE, 32'hFFFF_FFBE, 32'h0000_00BE};
        for (int i = 0; i < 4; i++) begin
            run_txn(1'b0, f3s[i], ads[i], 32'd0, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
            n_checks++;
            if (rd !== exs[i]) begin
                n_fail++; $display("FAIL load_ext_f3_%0d: got %h required %h", f3s[i], rd, exs[i]);
            end
        end
    endtask

    task automatic test_faults();
        run_txn(1'b0, 3'd2, 32'h5, 32'd0, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({lat, mis, ill, rd, a_we} !== {32'sd0, 1'b1, 1'b0, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL lw_misaligned: got lat=%0d mis=%b ill=%b rd=%h we=%b required 0/1/0/0/0",
                               lat, mis, ill, rd, a_we);
        end
        run_txn(1'b0, 3'd3, 32'h4, 32'd0, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({lat, mis, ill, rd} !== {32'sd0, 1'b0, 1'b1, 32'd0}) begin
            n_fail++; $display("FAIL load_illegal: got lat=%0d mis=%b ill=%b rd=%h required 0/0/1/0", lat, mis, ill, rd);
        end
        run_txn(1'b1, 3'd5, 32'h3, 32'h1234_5678, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({mis, ill, a_we} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL store_illegal_priority: got mis=%b ill=%b we=%b required 0/1/0", mis, ill, a_we);
        end
    endtask

    task automatic test_wrap();
        ref_step(1'b1, 3'd2, 32'h1004, 32'h0BAD_F00D, e_rd, e_mis, e_ill);
        run_txn(1'b1, 3'd2, 32'h1004, 32'h0BAD_F00D, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        n_checks++;
        if ({a_addr, mis, ill, dmem[1]} !== {10'd1, 2'b00, 32'h0BAD_F00D}) begin
            n_fail++; $display("FAIL addr_wrap: got addr=%h flags=%b%b word1=%h required 001/00/0badf00d",
                               a_addr, mis, ill, dmem[1]);
        end
    endtask

    task automatic test_reset_mid_access();
        ref_step(1'b1, 3'd2, 32'h8, 32'h1122_3344, e_rd, e_mis, e_ill);
        run_txn(1'b1, 3'd2, 32'h8, 32'h1122_3344, 1'b0, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'h8; req_wdata = 32'h5566_7788;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if (mem_write_enable !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_access_we: got %b required 1", mem_write_enable);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_write_enable, resp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL rst_async_we: got we=%b valid=%b required 0/0", mem_write_enable, resp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if ({dmem[2], req_ready, resp_valid} !== {32'h1122_3344, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL rst_mid_access: got word2=%h ready=%b valid=%b required 11223344/1/0",
                               dmem[2], req_ready, resp_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic        w, hold, fault;
        logic [2:0]  f3;
        logic [31:0] a, wd, emask_data, bmask;
        logic [3:0]  emask;
        int          bad;
        for (int t = 0; t < 150; t++) begin
            w = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7)); hold = 1'($urandom_range(0, 1));
            a = $urandom; wd = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            ref_step(w, f3, a, wd, e_rd, e_mis, e_ill);
            fault = e_mis || e_ill;
            emask = 4'b0000; emask_data = 32'd0;
            if (w && !fault)
                for (int i = 0; i < ref_size(f3); i++) begin
                    emask[int'(a[1:0]) + i] = 1'b1;
                    emask_data[8*(int'(a[1:0]) + i) +: 8] = wd[8*i +: 8];
                end
            bmask = {{8{emask[3]}}, {8{emask[2]}}, {8{emask[1]}}, {8{emask[0]}}};
            run_txn(w, f3, a, wd, hold, lat, rd, mis, ill, a_we, a_mask, a_data, a_addr, ovl);
            n_checks++;
            if (lat !== (fault ? 0 : 1)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", t, lat, fault ? 0 : 1); end
            n_checks++;
            if ({rd, mis, ill} !== {e_rd, e_mis, e_ill}) begin
                n_fail++; $display("FAIL rnd_resp[%0d] w=%b f3=%0d a=%h: got %h/%b%b required %h/%b%b",
                                   t, w, f3, a, rd, mis, ill, e_rd, e_mis, e_ill);
            end
            n_checks++;
            if ({a_we, a_mask} !== {w && !fault, emask}) begin
                n_fail++; $display("FAIL rnd_strobe[%0d]: got we=%b mask=%b required %b/%b", t, a_we, a_mask, w && !fault, emask);
            end
            n_checks++;
            if ((a_data & bmask) !== emask_data || (!fault && a_addr !== a[11:2])) begin
                n_fail++; $display("FAIL rnd_lanes[%0d]: got data=%h addr=%h required data=%h addr=%h",
                                   t, a_data & bmask, a_addr, emask_data, a[11:2]);
            end
            n_checks++;
            if (ovl !== 1'b0) begin n_fail++; $display("FAIL rnd_ready_overlap[%0d]: got 1 required 0", t); end
        end
        bad = 0;
        for (int i = 0; i < 1024; i++)
            if (dmem[i] !== {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]}) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL memory_image: got %0d differing words required 0", bad); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_lanes();
        test_load_extend();
        test_faults();
        test_wrap();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
